// File: rtl/rf_write_scheduler_pkg.sv
// Shared definitions for the register-file write scheduler.
package rf_write_scheduler_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Architectural zero register: never enqueued, never bypassed.
    localparam int unsigned REG_ZERO = 0;

    // One pending write-back at the default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] dst;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Result, commit and bypass signals of the write scheduler.
interface rf_write_scheduler_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_dst;
    logic [DATA_W-1:0] mem_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] byp_addr1;
    logic [ADDR_W-1:0] byp_addr2;
    logic              byp_hit1;
    logic [DATA_W-1:0] byp_data1;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data2;
    logic [CW-1:0]     count;

    // Scheduler side.
    modport slave (
        input  mem_valid, mem_dst, mem_data, alu_valid, alu_dst, alu_data,
        input  byp_addr1, byp_addr2,
        output mem_ready, alu_ready, rf_we, rf_waddr, rf_wdata,
        output byp_hit1, byp_data1, byp_hit2, byp_data2, count
    );

    // Execute/memory/decode side.
    modport master (
        output mem_valid, mem_dst, mem_data, alu_valid, alu_dst, alu_data,
        output byp_addr1, byp_addr2,
        input  mem_ready, alu_ready, rf_we, rf_waddr, rf_wdata,
        input  byp_hit1, byp_data1, byp_hit2, byp_data2, count
    );

endinterface

// File: rtl/wb_bypass_cam.sv
// Youngest-match search over the pending write queue for one bypass query.
module wb_bypass_cam
    import rf_write_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0]         dst_i  [DEPTH],
    input  logic [DATA_W-1:0]         data_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]  head_i,
    input  logic [$clog2(DEPTH):0]    count_i,
    input  logic [ADDR_W-1:0]         addr_i,
    output logic                      hit_o,
    output logic [DATA_W-1:0]         data_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] slot;

    // Walk from oldest to youngest so the last match seen wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        slot   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head_i + PW'(i);
            if ((CW'(i) < count_i) && (dst_i[slot] == addr_i) &&
                (addr_i != ADDR_W'(REG_ZERO))) begin
                hit_o  = 1'b1;
                data_o = data_i[slot];
            end
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// In-order write-back queue feeding the register-file write port, with bypass.
module rf_write_scheduler
    import rf_write_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    rf_write_scheduler_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] dst_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     free;
    logic [PW-1:0]     alu_slot;
    logic              pop, mem_acc, alu_acc, push_mem, push_alu;

    // Handshake decode; the head always retires, so its slot counts as free.
    always_comb begin
        pop           = (count_q != '0);
        free          = CW'(DEPTH) - count_q + CW'(pop);
        bus.mem_ready = rst_n & (free >= CW'(1));
        bus.alu_ready = rst_n & ((free >= CW'(2)) | ((free >= CW'(1)) & ~bus.mem_valid));
        mem_acc       = bus.mem_valid & bus.mem_ready;
        alu_acc       = bus.alu_valid & bus.alu_ready;
        push_mem      = mem_acc & (bus.mem_dst != ADDR_W'(REG_ZERO));
        push_alu      = alu_acc & (bus.alu_dst != ADDR_W'(REG_ZERO));
        alu_slot      = tail_q + PW'(push_mem);
        head_d        = head_q + PW'(pop);
        tail_d        = tail_q + PW'(push_mem) + PW'(push_alu);
        count_d       = count_q - CW'(pop) + CW'(push_mem) + CW'(push_alu);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; the load is older, so it takes the first free slot.
    always_ff @(posedge clk) begin
        if (push_mem) begin
            dst_q[tail_q]  <= bus.mem_dst;
            data_q[tail_q] <= bus.mem_data;
        end
        if (push_alu) begin
            dst_q[alu_slot]  <= bus.alu_dst;
            data_q[alu_slot] <= bus.alu_data;
        end
    end

    // Commit port presents the head; zeroed when nothing is pending.
    always_comb begin
        bus.rf_we    = pop;
        bus.rf_waddr = pop ? dst_q[head_q] : '0;
        bus.rf_wdata = pop ? data_q[head_q] : '0;
        bus.count    = count_q;
    end

    wb_bypass_cam #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_cam1 (
        .dst_i   (dst_q),
        .data_i  (data_q),
        .head_i  (head_q),
        .count_i (count_q),
        .addr_i  (bus.byp_addr1),
        .hit_o   (bus.byp_hit1),
        .data_o  (bus.byp_data1)
    );

    wb_bypass_cam #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_cam2 (
        .dst_i   (dst_q),
        .data_i  (data_q),
        .head_i  (head_q),
        .count_i (count_q),
        .addr_i  (bus.byp_addr2),
        .hit_o   (bus.byp_hit2),
        .data_o  (bus.byp_data2)
    );

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Scoreboard bench for rf_write_scheduler with a queue-based reference model.
module tb_rf_write_scheduler;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
    } ent_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    ent_t pend[$];   // model of queue contents, oldest first
    ent_t exp_q[$];  // expected commits not yet seen by the monitor

    rf_write_scheduler_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) bus ();

    rf_write_scheduler #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 0) begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].dst == a) begin
                    h = 1'b1;
                    d = pend[i].data;
                    break;
                end
            end
        end
    endfunction

    // One cycle: drive, check ready/occupancy/bypass, then update the model at the edge.
    task automatic drive_cycle(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                               input logic av, input logic [4:0] ad, input logic [31:0] adat,
                               input logic [4:0] b1, input logic [4:0] b2,
                               output bit macc, output bit aacc);
        int          n;
        int          free;
        logic        exp_mr, exp_ar, h;
        logic [31:0] d;
        bus.mem_valid = mv;  bus.mem_dst = md;  bus.mem_data = mdat;
        bus.alu_valid = av;  bus.alu_dst = ad;  bus.alu_data = adat;
        bus.byp_addr1 = b1;  bus.byp_addr2 = b2;
        #1;
        n      = pend.size();
        free   = DEPTH - n + ((n != 0) ? 1 : 0);
        exp_mr = (free >= 1);
        exp_ar = (free >= 2) || ((free >= 1) && !mv);
        chk("mem_ready", 64'(bus.mem_ready), 64'(exp_mr));
        chk("alu_ready", 64'(bus.alu_ready), 64'(exp_ar));
        chk("rf_we", 64'(bus.rf_we), 64'(n != 0));
        chk("count", 64'(bus.count), 64'(n));
        lookup(b1, h, d);
        chk("byp_hit1", 64'(bus.byp_hit1), 64'(h));
        chk("byp_data1", 64'(bus.byp_data1), 64'(d));
        lookup(b2, h, d);
        chk("byp_hit2", 64'(bus.byp_hit2), 64'(h));
        chk("byp_data2", 64'(bus.byp_data2), 64'(d));
        macc = mv && exp_mr;
        aacc = av && exp_ar;
        @(posedge clk);
        if (pend.size() != 0) void'(pend.pop_front());
        if (macc && md != 0) begin
            pend.push_back('{dst: md, data: mdat});
            exp_q.push_back('{dst: md, data: mdat});
        end
        if (aacc && ad != 0) begin
            pend.push_back('{dst: ad, data: adat});
            exp_q.push_back('{dst: ad, data: adat});
        end
        #1;
    endtask

    task automatic idle(input int cycles);
        bit ma, aa;
        for (int i = 0; i < cycles; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, ma, aa);
    endtask

    // Monitor: every cycle the commit port is active must match the next expected write.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL commit_unexpected: got r%0d=%0h expected no write at %0t",
                             bus.rf_waddr, bus.rf_wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_addr", 64'(bus.rf_waddr), 64'(e.dst));
                    chk("commit_data", 64'(bus.rf_wdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          ma, aa;
        int          nd;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.mem_valid = 0;  bus.mem_dst = 0;  bus.mem_data = 0;
        bus.alu_valid = 1;  bus.alu_dst = 5;  bus.alu_data = 32'h1234;
        bus.byp_addr1 = 0;  bus.byp_addr2 = 0;
        #3;
        chk("rst_mem_ready", 64'(bus.mem_ready), 64'(0));
        chk("rst_alu_ready", 64'(bus.alu_ready), 64'(0));
        chk("rst_rf_we", 64'(bus.rf_we), 64'(0));
        chk("rst_count", 64'(bus.count), 64'(0));
        bus.alu_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single ALU result, one-cycle commit.
        drive_cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, ma, aa);
        idle(2);

        // Same-register load and ALU result; ALU is younger.
        drive_cycle(1, 3, 32'h11, 1, 3, 32'h22, 0, 0, ma, aa);
        drive_cycle(0, 0, 0, 0, 0, 0, 3, 0, ma, aa);
        idle(2);

        // Writes to r0 are accepted and dropped.
        drive_cycle(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, ma, aa);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, ma, aa);

        // Both sources every cycle until r1..r10 are accepted.
        nd = 1;
        for (int c = 0; c < 30 && nd <= 10; c++) begin
            drive_cycle(1, 5'(nd), 32'h100 + 32'(nd), (nd + 1 <= 10), 5'(nd + 1),
                        32'h100 + 32'(nd + 1), 5'(nd - 1), 5'(nd), ma, aa);
            nd += int'(ma) + int'(aa);
        end
        idle(6);

        // Asynchronous reset with three entries pending.
        drive_cycle(1, 1, 32'hA1, 1, 2, 32'hA2, 0, 0, ma, aa);
        drive_cycle(1, 3, 32'hA3, 1, 4, 32'hA4, 0, 0, ma, aa);
        bus.mem_valid = 0;
        bus.alu_valid = 0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rf_we", 64'(bus.rf_we), 64'(0));
        chk("arst_count", 64'(bus.count), 64'(0));
        chk("arst_rf_waddr", 64'(bus.rf_waddr), 64'(0));
        chk("arst_rf_wdata", 64'(bus.rf_wdata), 64'(0));
        chk("arst_mem_ready", 64'(bus.mem_ready), 64'(0));
        pend.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Bypass hit and miss with two entries queued.
        drive_cycle(1, 7, 32'hA, 1, 9, 32'hB, 0, 0, ma, aa);
        drive_cycle(0, 0, 0, 0, 0, 0, 9, 4, ma, aa);
        idle(3);

        // Random traffic over a small register range to force repeats and r0.
        for (int c = 0; c < 400; c++) begin
            drive_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ma, aa);
        end

        idle(DEPTH + 4);
        chk("drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
